// File: rtl/fb_pkg.sv
// Framebuffer geometry, shared bus widths and the scanout/raster arbiter state encoding.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 640;
    localparam int unsigned FB_HEIGHT = 400;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    localparam int FB_ADDR_W = 18;
    localparam int FB_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr < FB_PIXELS;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO holding {addr,data} pixel writes; head entry is visible combinationally.
module fb_wr_fifo #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 8
) (
    input  logic                         I_CLOCK,
    input  logic                         I_RESET,
    input  logic                         I_PUSH,
    input  logic [WIDTH-1:0]             I_PUSH_DATA,
    input  logic                         I_POP,
    output logic [WIDTH-1:0]             O_HEAD,
    output logic                         O_FULL,
    output logic                         O_EMPTY,
    output logic [$clog2(DEPTH):0]       O_COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Falling-edge clocking matches the rest of the raster pipeline.
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (I_PUSH) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (I_POP)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({I_PUSH, I_POP})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_PUSH) r_mem[r_wr_ptr] <= I_PUSH_DATA;
    end

    assign O_HEAD  = r_mem[r_rd_ptr];
    assign O_FULL  = (r_count == CNT_W'(DEPTH));
    assign O_EMPTY = (r_count == '0);
    assign O_COUNT = r_count;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: scanout reads vs buffered rasterizer writes,
// with bounded write starvation and a flush/drain handshake before buffer swaps.
//
// state    | meaning
// ST_RUN   | normal operation, write intake open
// ST_DRAIN | intake closed, waiting for FIFO empty and last write retired
// ST_DONE  | one-cycle flush-done pulse, then back to ST_RUN
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH    = FB_ADDR_W,
    parameter int DATA_WIDTH    = FB_DATA_W,
    parameter int FIFO_DEPTH    = 8,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_WR_VALID,
    input  logic [ADDR_WIDTH-1:0] I_WR_ADDR,
    input  logic [DATA_WIDTH-1:0] I_WR_DATA,
    output logic                  O_WR_READY,
    output logic                  O_FRAMESTALL,
    input  logic                  I_RD_REQ,
    input  logic [ADDR_WIDTH-1:0] I_RD_ADDR,
    output logic                  O_RD_GNT,
    output logic                  O_RD_VALID,
    output logic [DATA_WIDTH-1:0] O_RD_DATA,
    output logic                  O_MEM_EN,
    output logic                  O_MEM_WE,
    output logic [ADDR_WIDTH-1:0] O_MEM_ADDR,
    output logic [DATA_WIDTH-1:0] O_MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] I_MEM_RDATA,
    input  logic                  I_FLUSH,
    output logic                  O_FLUSH_DONE,
    output logic [7:0]            O_DROP_CNT
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                  r_alive;
    logic [STREAK_W-1:0]   r_streak;
    logic [7:0]            r_drop_cnt;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rd_p1;
    logic                  r_rd_valid;

    logic                  w_take;
    logic                  w_in_range;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_gnt;
    logic                  w_streak_max;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;

    fb_wr_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .I_CLOCK     (I_CLOCK),
        .I_RESET     (I_RESET),
        .I_PUSH      (w_push),
        .I_PUSH_DATA ({I_WR_ADDR, I_WR_DATA}),
        .I_POP       (w_pop),
        .O_HEAD      ({w_head_addr, w_head_data}),
        .O_FULL      (w_fifo_full),
        .O_EMPTY     (w_fifo_empty),
        .O_COUNT     (w_fifo_count)
    );

    // r_alive keeps ready and grant low until the first edge after reset release.
    assign O_WR_READY   = r_alive && !w_fifo_full && (r_state == ST_RUN);
    assign w_take       = I_WR_VALID && O_WR_READY;
    assign w_in_range   = addr_in_range(32'(I_WR_ADDR));
    assign w_push       = w_take && w_in_range;
    assign w_streak_max = (r_streak == STREAK_W'(MAX_RD_STREAK));
    assign w_rd_gnt     = r_alive && I_RD_REQ && !(!w_fifo_empty && w_streak_max);
    assign w_pop        = !w_rd_gnt && !w_fifo_empty;

    assign O_RD_GNT     = w_rd_gnt;
    assign O_FRAMESTALL = w_fifo_full;
    assign O_FLUSH_DONE = (r_state == ST_DONE);
    assign O_DROP_CNT   = r_drop_cnt;
    assign O_MEM_EN     = r_mem_en;
    assign O_MEM_WE     = r_mem_we;
    assign O_MEM_ADDR   = r_mem_addr;
    assign O_MEM_WDATA  = r_mem_wdata;
    assign O_RD_VALID   = r_rd_valid;
    assign O_RD_DATA    = r_rd_valid ? I_MEM_RDATA : '0;

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) r_state <= ST_RUN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (I_FLUSH) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if ((w_fifo_count == '0) && !r_mem_we) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_alive     <= 1'b0;
            r_streak    <= '0;
            r_drop_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_p1     <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_alive    <= 1'b1;
            r_mem_en   <= w_rd_gnt || w_pop;
            r_mem_we   <= w_pop;
            r_rd_p1    <= w_rd_gnt;
            r_rd_valid <= r_rd_p1;
            if (w_rd_gnt) begin
                r_mem_addr <= I_RD_ADDR;
            end else if (w_pop) begin
                r_mem_addr  <= w_head_addr;
                r_mem_wdata <= w_head_data;
            end
            // Streak only counts reads that overtook a waiting write.
            if (w_rd_gnt && !w_fifo_empty) r_streak <= r_streak + STREAK_W'(1);
            else                           r_streak <= '0;
            if (w_take && !w_in_range && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: vector table, directed corner sequences and a random run
// compared against a queue-based reference model with a behavioural SRAM.
module tb_fb_arbiter;
    import fb_pkg::*;

    localparam int AW    = 18;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int MAXS  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          O_WR_READY, O_FRAMESTALL, O_RD_GNT, O_RD_VALID;
    logic [DW-1:0] O_RD_DATA, O_MEM_WDATA;
    logic          O_MEM_EN, O_MEM_WE, O_FLUSH_DONE;
    logic [AW-1:0] O_MEM_ADDR;
    logic [7:0]    O_DROP_CNT;

    always #5 clk = ~clk;

    fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_RD_STREAK(MAXS)) dut (
        .I_CLOCK(clk), .I_RESET(rst),
        .I_WR_VALID(wr_valid), .I_WR_ADDR(wr_addr), .I_WR_DATA(wr_data),
        .O_WR_READY(O_WR_READY), .O_FRAMESTALL(O_FRAMESTALL),
        .I_RD_REQ(rd_req), .I_RD_ADDR(rd_addr), .O_RD_GNT(O_RD_GNT),
        .O_RD_VALID(O_RD_VALID), .O_RD_DATA(O_RD_DATA),
        .O_MEM_EN(O_MEM_EN), .O_MEM_WE(O_MEM_WE), .O_MEM_ADDR(O_MEM_ADDR),
        .O_MEM_WDATA(O_MEM_WDATA), .I_MEM_RDATA(mem_rdata),
        .I_FLUSH(flush), .O_FLUSH_DONE(O_FLUSH_DONE), .O_DROP_CNT(O_DROP_CNT)
    );

    // Behavioural single-port SRAM, one-cycle read latency.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    always @(negedge clk) begin
        if (O_MEM_EN) begin
            if (O_MEM_WE) sram[O_MEM_ADDR] <= O_MEM_WDATA;
            else          mem_rdata <= sram[O_MEM_ADDR];
        end
    end

    // Reference model state.
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    wr_t           wq[$];
    logic [DW-1:0] mmem [int];
    int            streak, mode, drop;
    bit            alive;
    bit            e_en, e_we, e_valid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    bit            s_ready, s_stall, s_gnt, s_en, s_we, s_valid, s_done;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rdata;
    logic [7:0]    s_drop;
    int            s_qsize;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        streak = 0; mode = 0; drop = 0; alive = 0;
        e_en = 0; e_we = 0; e_valid = 0; e_rdata = '0;
    endtask

    // One cycle: inputs already driven; sample at posedge, advance model, return after negedge.
    task automatic cycle();
        bit ready_e, gnt_e, pop_e, nv;
        int qn, nmode;
        logic [DW-1:0] nd;
        wr_t w;
        @(posedge clk);
        s_ready = O_WR_READY; s_stall = O_FRAMESTALL; s_gnt = O_RD_GNT;
        s_en = O_MEM_EN; s_we = O_MEM_WE; s_addr = O_MEM_ADDR; s_valid = O_RD_VALID;
        s_rdata = O_RD_DATA; s_done = O_FLUSH_DONE; s_drop = O_DROP_CNT;
        qn = wq.size(); s_qsize = qn;
        ready_e = alive && qn < DEPTH && mode == 0;
        gnt_e   = alive && rd_req && !(qn > 0 && streak == MAXS);
        pop_e   = !gnt_e && qn > 0;
        chk("wr_ready", s_ready, ready_e);
        chk("framestall", s_stall, qn == DEPTH);
        chk("rd_gnt", s_gnt, gnt_e);
        chk("flush_done", s_done, mode == 2);
        chk("mem_en", s_en, e_en);
        if (e_en) chk("mem_we", s_we, e_we);
        if (e_en) chk("mem_addr", s_addr, e_addr);
        if (e_en && e_we) chk("mem_wdata", O_MEM_WDATA, e_wdata);
        chk("rd_valid", s_valid, e_valid);
        chk("rd_data", s_rdata, e_rdata);
        chk("drop_cnt", s_drop, drop);
        if (e_en && e_we) mmem[int'(e_addr)] = e_wdata;
        nv = e_en && !e_we;
        nd = (nv && mmem.exists(int'(e_addr))) ? mmem[int'(e_addr)] : '0;
        nmode = mode;
        if (mode == 0 && flush) nmode = 1;
        else if (mode == 1 && qn == 0 && !(e_en && e_we)) nmode = 2;
        else if (mode == 2) nmode = 0;
        e_en = gnt_e || pop_e;
        e_we = pop_e;
        if (gnt_e) e_addr = rd_addr;
        else if (pop_e) begin
            w = wq.pop_front();
            e_addr = w.addr; e_wdata = w.data;
        end
        streak = (gnt_e && qn > 0) ? streak + 1 : 0;
        if (wr_valid && ready_e) begin
            if (int'(wr_addr) < int'(FB_PIXELS)) wq.push_back('{wr_addr, wr_data});
            else if (drop < 255) drop++;
        end
        e_valid = nv; e_rdata = nd; mode = nmode; alive = 1;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 0; rd_req = 0; flush = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctl"}, {O_WR_READY, O_FRAMESTALL, O_RD_GNT, O_RD_VALID, O_MEM_EN, O_MEM_WE, O_FLUSH_DONE}, '0);
        chk({name, "_addr"}, O_MEM_ADDR, '0);
        chk({name, "_wdata"}, O_MEM_WDATA, '0);
        chk({name, "_rdata"}, O_RD_DATA, '0);
        chk({name, "_drop"}, O_DROP_CNT, '0);
    endtask

    task automatic release_reset();
        rd_req = 0; wr_valid = 0; flush = 0;
        @(posedge clk); rst = 0;
        @(negedge clk); #1;
        alive = 1;
    endtask

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; bit stored; int drop_after; } vec_t;
    vec_t tbl[5];

    initial begin
        int acc, gap, max_gap, run, max_run, pulses, rd_in_drain, extra, cnt_we, cnt_val, guard;
        bit stall_seen;
        tbl[0] = '{18'h00010, 64'hA5, 1'b1, 0};
        tbl[1] = '{18'd256000, 64'h11, 1'b0, 1};
        tbl[2] = '{18'd262143, 64'h22, 1'b0, 2};
        tbl[3] = '{18'd255999, 64'h33, 1'b1, 2};
        tbl[4] = '{18'd0,      64'h44, 1'b1, 2};

        model_reset();
        rd_req = 1;
        #2;
        check_all_zero("reset");
        release_reset();
        idle(1);
        chk("ready_after_reset", s_ready, 1);

        // Single writes into an empty FIFO: WE appears two cycles after the accept.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_addr = tbl[i].addr; wr_data = tbl[i].data;
            cycle();
            wr_valid = 0;
            cycle();
            cycle();
            chk("tbl_we", s_we, tbl[i].stored);
            if (tbl[i].stored) chk("tbl_addr", s_addr, tbl[i].addr);
            chk("tbl_drop", s_drop, tbl[i].drop_after);
        end

        // Readback, latency 2.
        rd_req = 1; rd_addr = 18'h00010;
        cycle(); chk("rb_gnt", s_gnt, 1);
        rd_req = 0;
        cycle(); chk("rb_en_rd", {s_en, s_we, 32'(s_addr)}, {1'b1, 1'b0, 32'h10});
        cycle(); chk("rb_data", {s_valid, s_rdata}, {1'b1, 64'hA5});

        // Drop counter saturation.
        wr_valid = 1;
        for (int i = 0; i < 300; i++) begin
            wr_addr = AW'(256000 + $urandom_range(0, 6143));
            cycle();
        end
        idle(1);
        chk("drop_sat", s_drop, 255);

        // Write burst under continuous reads: starvation bound and read gaps.
        idle(3);
        rd_req = 1; wr_valid = 1; acc = 0; guard = 0; stall_seen = 0;
        gap = 0; max_gap = 0; run = 0; max_run = 0;
        while (guard < 200 && (acc < 9 || s_qsize > 0 || wq.size() > 0)) begin
            rd_addr = AW'($urandom_range(0, 63));
            wr_addr = AW'($urandom_range(64, 127)); wr_data = {$urandom, $urandom};
            wr_valid = (acc < 9);
            cycle();
            guard++;
            if (s_ready && wr_valid) acc++;
            if (s_stall) stall_seen = 1;
            gap = s_gnt ? 0 : gap + 1;
            if (gap > max_gap) max_gap = gap;
            run = (s_gnt && s_qsize > 0) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        chk("burst_accepts", acc, 9);
        chk("burst_stall_seen", stall_seen, 1);
        chk("burst_max_rd_gap", max_gap, 1);
        chk("burst_max_streak", max_run, MAXS);

        // Flush with 5 writes queued.
        idle(3);
        rd_req = 1; wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            wr_addr = AW'(200 + i); wr_data = 64'hF0 + 64'(i);
            rd_addr = AW'(i);
            cycle();
        end
        rd_req = 0; wr_valid = 1; flush = 1;
        cycle();
        flush = 0; pulses = 0; rd_in_drain = 0;
        for (int i = 0; i < 30; i++) begin
            if (pulses > 0) wr_valid = 0;
            cycle();
            if (pulses == 0 && s_ready) rd_in_drain++;
            if (s_done) pulses++;
        end
        chk("flush_pulses", pulses, 1);
        chk("flush_ready_low", rd_in_drain, 0);
        chk("flush_ready_back", s_ready, 1);
        chk("flush_mem_200", mmem.exists(200) ? mmem[200] : '0, 64'hF0);
        chk("flush_mem_204", mmem.exists(204) ? mmem[204] : '0, 64'hF4);

        // Flush on empty FIFO, second flush during DRAIN ignored.
        idle(3);
        flush = 1; cycle();
        cycle(); chk("flush_empty_k1", s_done, 0);
        flush = 0;
        cycle(); chk("flush_empty_k2", s_done, 1);
        extra = 0;
        for (int i = 0; i < 5; i++) begin cycle(); if (s_done) extra++; end
        chk("flush_no_extra", extra, 0);

        // Reset mid-operation.
        rd_req = 1; wr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(300 + i); wr_data = 64'hB0 + 64'(i); rd_addr = AW'(i);
            cycle();
        end
        wr_valid = 0;
        @(posedge clk);
        chk("pre_reset_gnt", O_RD_GNT, 1);
        rst = 1; #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk); @(negedge clk);
        release_reset();
        cnt_we = 0; cnt_val = 0;
        for (int i = 0; i < 6; i++) begin cycle(); cnt_we += int'(s_we); cnt_val += int'(s_valid); end
        chk("post_reset_we", cnt_we, 0);
        chk("post_reset_valid", cnt_val, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = ($urandom_range(0, 15) == 0) ? AW'(256000 + $urandom_range(0, 6143))
                                                    : AW'($urandom_range(0, 63));
            wr_data  = {$urandom, $urandom};
            rd_req   = ($urandom_range(0, 9) < 7);
            rd_addr  = AW'($urandom_range(0, 63));
            flush    = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
